// File: rtl/cpu_wb_pkg.sv
// Shared write-back definitions: register address width, default data width
// and the layout of a queued MDU result.
package cpu_wb_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int XLEN_DEFAULT = 32;
    localparam int NUM_REGS     = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]   rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding MDU results that lost arbitration to the
// in-order pipeline; wrap-around pointers plus an occupancy count.
module wb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_write_sequencer.sv
// Register-file write-port sequencer: merges in-order pipeline results with
// out-of-order MDU results and tracks outstanding MDU destinations (BUSY/KILL).
module wb_write_sequencer
    import cpu_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PIPE_VALID,
    input  logic [REG_ADDR_W-1:0] PIPE_RD,
    input  logic [XLEN-1:0]       PIPE_DATA,
    input  logic                  ISSUE_VALID,
    input  logic [REG_ADDR_W-1:0] ISSUE_RD,
    input  logic                  MDU_VALID,
    input  logic [REG_ADDR_W-1:0] MDU_RD,
    input  logic [XLEN-1:0]       MDU_DATA,
    output logic                  MDU_READY,
    output logic                  WRITE_ENABLE,
    output logic [REG_ADDR_W-1:0] WB_ADDRESS,
    output logic [XLEN-1:0]       WRITE_DATA,
    output logic [NUM_REGS-1:0]   BUSY
);

    localparam int ENTRY_W = REG_ADDR_W + XLEN;

    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [NUM_REGS-1:0]   kill_q, kill_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]    fifo_head;

    logic                  pipe_wr, mdu_take;
    logic                  ret_valid;
    logic [REG_ADDR_W-1:0] ret_rd;
    logic [XLEN-1:0]       ret_data;

    wb_result_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (fifo_push),
        .din   ({MDU_RD, MDU_DATA}),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign MDU_READY = !fifo_full;
    assign pipe_wr   = PIPE_VALID && (PIPE_RD != '0);
    // Results for x0 are acknowledged but never reach the queue or the port.
    assign mdu_take  = MDU_VALID && MDU_READY && (MDU_RD != '0);

    always_comb begin
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        kill_d    = kill_q;
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;
        ret_valid = 1'b0;
        ret_rd    = '0;
        ret_data  = '0;

        if (pipe_wr) begin
            we_d   = 1'b1;
            addr_d = PIPE_RD;
            data_d = PIPE_DATA;
            if (busy_q[PIPE_RD]) begin
                kill_d[PIPE_RD] = 1'b1;
            end
            fifo_push = mdu_take;
        end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            ret_valid = 1'b1;
            ret_rd    = fifo_head[ENTRY_W-1 -: REG_ADDR_W];
            ret_data  = fifo_head[XLEN-1:0];
            fifo_push = mdu_take;
        end else if (mdu_take) begin
            ret_valid = 1'b1;
            ret_rd    = MDU_RD;
            ret_data  = MDU_DATA;
        end

        // A result overtaken by a younger pipeline write is retired silently.
        if (ret_valid) begin
            busy_d[ret_rd] = 1'b0;
            if (kill_q[ret_rd]) begin
                kill_d[ret_rd] = 1'b0;
            end else begin
                we_d   = 1'b1;
                addr_d = ret_rd;
                data_d = ret_data;
            end
        end

        if (ISSUE_VALID && (ISSUE_RD != '0)) begin
            busy_d[ISSUE_RD] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            busy_q <= '0;
            kill_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            busy_q <= busy_d;
            kill_q <= kill_d;
        end
    end

    assign WRITE_ENABLE = we_q;
    assign WB_ADDRESS   = addr_q;
    assign WRITE_DATA   = data_q;
    assign BUSY         = busy_q;

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Directed bench for wb_write_sequencer: expected register-file writes are
// queued as stimulus is issued and a monitor matches every WRITE_ENABLE.
module tb_wb_write_sequencer;
    import cpu_wb_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        PIPE_VALID;
    logic [4:0]  PIPE_RD;
    logic [31:0] PIPE_DATA;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_RD;
    logic        MDU_VALID;
    logic [4:0]  MDU_RD;
    logic [31:0] MDU_DATA;
    logic        MDU_READY;
    logic        WRITE_ENABLE;
    logic [4:0]  WB_ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] BUSY;

    int checks = 0;
    int errors = 0;
    wb_entry_t exp_q[$];

    wb_write_sequencer #(.DEPTH(2), .XLEN(32)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PIPE_VALID   (PIPE_VALID),
        .PIPE_RD      (PIPE_RD),
        .PIPE_DATA    (PIPE_DATA),
        .ISSUE_VALID  (ISSUE_VALID),
        .ISSUE_RD     (ISSUE_RD),
        .MDU_VALID    (MDU_VALID),
        .MDU_RD       (MDU_RD),
        .MDU_DATA     (MDU_DATA),
        .MDU_READY    (MDU_READY),
        .WRITE_ENABLE (WRITE_ENABLE),
        .WB_ADDRESS   (WB_ADDRESS),
        .WRITE_DATA   (WRITE_DATA),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        PIPE_VALID  = 1'b0; PIPE_RD  = '0; PIPE_DATA = '0;
        ISSUE_VALID = 1'b0; ISSUE_RD = '0;
        MDU_VALID   = 1'b0; MDU_RD   = '0; MDU_DATA  = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        clear_inputs();
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        wb_entry_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
        PIPE_VALID = 1'b1; PIPE_RD = rd; PIPE_DATA = d;
    endtask

    task automatic mdu(input logic [4:0] rd, input logic [31:0] d);
        MDU_VALID = 1'b1; MDU_RD = rd; MDU_DATA = d;
    endtask

    task automatic issue(input logic [4:0] rd);
        ISSUE_VALID = 1'b1; ISSUE_RD = rd;
    endtask

    // Monitor: every register-file write must match the head of the queue.
    always @(negedge CLK) begin
        if (WRITE_ENABLE === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h, none expected",
                         WB_ADDRESS, WRITE_DATA);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                if (WB_ADDRESS !== e.rd || WRITE_DATA !== e.data) begin
                    errors++;
                    $display("FAIL write_match: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                             WB_ADDRESS, WRITE_DATA, e.rd, e.data);
                end
            end
        end
    end

    always @(posedge CLK) begin
        if (!RESET && ISSUE_VALID && ISSUE_RD != 0 && BUSY[ISSUE_RD]) begin
            errors++;
            $display("FAIL issue_protocol: issue to busy rd=%0d", ISSUE_RD);
        end
    end

    initial begin
        clear_inputs();
        RESET = 1'b1;
        #2;
        chk("reset_we",    64'(WRITE_ENABLE), 64'd0);
        chk("reset_addr",  64'(WB_ADDRESS),   64'd0);
        chk("reset_data",  64'(WRITE_DATA),   64'd0);
        chk("reset_busy",  64'(BUSY),         64'd0);
        chk("reset_ready", 64'(MDU_READY),    64'd1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        tick();

        // Pipeline-only writes, then a write aimed at x0.
        pipe(5'd5, 32'hDEADBEEF); expect_wr(5'd5, 32'hDEADBEEF); tick();
        pipe(5'd0, 32'h00000001); tick();
        tick();

        // Bypass: MDU result with no pipe contention takes one cycle.
        issue(5'd7); tick();
        chk("busy7_set", 64'(BUSY[7]), 64'd1);
        tick(); tick();
        chk("bypass_ready", 64'(MDU_READY), 64'd1);
        mdu(5'd7, 32'h12); expect_wr(5'd7, 32'h12); tick();
        chk("busy7_clr", 64'(BUSY[7]), 64'd0);
        tick();

        // Contention: pipe hogs the port while the FIFO fills.
        issue(5'd8);  tick();
        issue(5'd9);  tick();
        issue(5'd10); tick();
        chk("busy_8_10", 64'(BUSY), 64'h0000_0700);
        for (int i = 0; i < 4; i++) begin
            pipe(5'(20 + i), 32'h100 + i);
            expect_wr(5'(20 + i), 32'h100 + i);
            case (i)
                0: begin chk("ready_c0", 64'(MDU_READY), 64'd1); mdu(5'd8, 32'h808); end
                1: begin chk("ready_c1", 64'(MDU_READY), 64'd1); mdu(5'd9, 32'h909); end
                2: begin chk("ready_c2", 64'(MDU_READY), 64'd0); mdu(5'd10, 32'hA0A); end
                default: begin chk("ready_c3", 64'(MDU_READY), 64'd0); mdu(5'd10, 32'hA0A); end
            endcase
            tick();
        end
        chk("ready_c4", 64'(MDU_READY), 64'd0);
        mdu(5'd10, 32'hA0A); expect_wr(5'd8, 32'h808); tick();
        chk("ready_c5", 64'(MDU_READY), 64'd1);
        mdu(5'd10, 32'hA0A); expect_wr(5'd9, 32'h909); tick();
        chk("ready_c6", 64'(MDU_READY), 64'd1);
        expect_wr(5'd10, 32'hA0A); tick();
        chk("busy_after_drain", 64'(BUSY), 64'd0);
        tick();

        // WAW kill: the younger pipeline write survives, the MDU result is dropped.
        issue(5'd3); tick();
        pipe(5'd3, 32'hA); expect_wr(5'd3, 32'hA); tick();
        mdu(5'd3, 32'hB); tick();
        chk("busy3_after_kill", 64'(BUSY[3]), 64'd0);
        issue(5'd3); tick();
        mdu(5'd3, 32'hC); expect_wr(5'd3, 32'hC); tick();
        chk("busy3_after_write", 64'(BUSY[3]), 64'd0);

        // x0: issue ignored, MDU result accepted and dropped.
        issue(5'd0); tick();
        chk("busy_x0_issue", 64'(BUSY), 64'd0);
        chk("ready_x0", 64'(MDU_READY), 64'd1);
        mdu(5'd0, 32'h55); tick();
        tick();

        // Reset with two queued results and outstanding BUSY bits.
        issue(5'd11); tick();
        issue(5'd12); tick();
        pipe(5'd1, 32'h1111); mdu(5'd11, 32'hB0B); expect_wr(5'd1, 32'h1111); tick();
        pipe(5'd2, 32'h2222); mdu(5'd12, 32'hC0C); expect_wr(5'd2, 32'h2222); tick();
        chk("pre_reset_ready", 64'(MDU_READY), 64'd0);
        chk("pre_reset_busy",  64'(BUSY), 64'h0000_1800);
        @(negedge CLK); #1;
        RESET = 1'b1;
        #1;
        chk("mid_reset_we",    64'(WRITE_ENABLE), 64'd0);
        chk("mid_reset_addr",  64'(WB_ADDRESS),   64'd0);
        chk("mid_reset_data",  64'(WRITE_DATA),   64'd0);
        chk("mid_reset_busy",  64'(BUSY),         64'd0);
        chk("mid_reset_ready", 64'(MDU_READY),    64'd1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("post_reset_busy", 64'(BUSY), 64'd0);
        chk("expect_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
